// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: default widths,
// FSM state encoding and requester identifiers.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on contention the
// requester that did not win most recently is chosen. Purely combinational.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,   // id of the most recent winner (REQ_I or REQ_D)
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[REQ_I] && req[REQ_D]) begin
      gnt = 2'b00;
      if (last == 1'(REQ_D)) gnt[REQ_I] = 1'b1;
      else                   gnt[REQ_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port
// synchronous memory; one access every two cycles, round-robin on contention.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  state_t            state_reg, state_next;
  logic              last_reg, last_next;   // winner of the access in flight / most recent
  logic              load_reg, load_next;
  logic              i_gnt_reg, i_gnt_next, d_gnt_reg, d_gnt_next;
  logic              i_rvalid_reg, i_rvalid_next, d_rvalid_reg, d_rvalid_next;
  logic              m_en_reg, m_en_next, m_we_reg, m_we_next;
  logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
  logic [DATA_W-1:0] i_rdata_reg, i_rdata_next, d_rdata_reg, d_rdata_next;
  logic [15:0]       gnt_cnt_i, gnt_cnt_i_next, gnt_cnt_d, gnt_cnt_d_next;
  logic [1:0]        req_vec, pick;
  logic              grant;

  assign req_vec[REQ_I] = i_req;
  assign req_vec[REQ_D] = d_req;

  rr_arb2 u_rr (
    .req  (req_vec),
    .last (last_reg),
    .gnt  (pick)
  );

  // The memory's own read register supplies the data during the rvalid cycle;
  // the hold registers keep the last delivered word afterwards.
  assign i_rdata  = i_rvalid_reg ? m_rdata : i_rdata_reg;
  assign d_rdata  = d_rvalid_reg ? m_rdata : d_rdata_reg;
  assign i_gnt    = i_gnt_reg;
  assign d_gnt    = d_gnt_reg;
  assign i_rvalid = i_rvalid_reg;
  assign d_rvalid = d_rvalid_reg;
  assign m_en     = m_en_reg;
  assign m_we     = m_we_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_reg     <= 1'(REQ_I);   // data port wins the first contention
      load_reg     <= 1'b0;
      i_gnt_reg    <= 1'b0;
      d_gnt_reg    <= 1'b0;
      i_rvalid_reg <= 1'b0;
      d_rvalid_reg <= 1'b0;
      m_en_reg     <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      gnt_cnt_i    <= '0;
      gnt_cnt_d    <= '0;
    end else begin
      state_reg    <= state_next;
      last_reg     <= last_next;
      load_reg     <= load_next;
      i_gnt_reg    <= i_gnt_next;
      d_gnt_reg    <= d_gnt_next;
      i_rvalid_reg <= i_rvalid_next;
      d_rvalid_reg <= d_rvalid_next;
      m_en_reg     <= m_en_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      i_rdata_reg  <= i_rdata_next;
      d_rdata_reg  <= d_rdata_next;
      gnt_cnt_i    <= gnt_cnt_i_next;
      gnt_cnt_d    <= gnt_cnt_d_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    load_next      = load_reg;
    i_gnt_next     = 1'b0;
    d_gnt_next     = 1'b0;
    i_rvalid_next  = 1'b0;
    d_rvalid_next  = 1'b0;
    m_en_next      = 1'b0;
    m_we_next      = 1'b0;
    m_addr_next    = m_addr_reg;
    m_wdata_next   = m_wdata_reg;
    i_rdata_next   = i_rvalid_reg ? m_rdata : i_rdata_reg;
    d_rdata_next   = d_rvalid_reg ? m_rdata : d_rdata_reg;
    gnt_cnt_i_next = gnt_cnt_i;
    gnt_cnt_d_next = gnt_cnt_d;
    grant          = 1'b0;

    case (state_reg)
      IDLE:  grant = |pick;
      GRANT: begin
        state_next = RESP;
        if (load_reg) begin
          if (last_reg == 1'(REQ_D)) d_rvalid_next = 1'b1;
          else                       i_rvalid_next = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
        grant      = |pick;
      end
      default: state_next = IDLE;
    endcase

    // Arbitration edge: capture the winner's request so later input changes
    // cannot disturb the access in flight.
    if (grant) begin
      state_next = GRANT;
      m_en_next  = 1'b1;
      last_next  = pick[REQ_D];
      if (pick[REQ_D]) begin
        d_gnt_next     = 1'b1;
        m_addr_next    = d_addr;
        m_we_next      = d_we;
        m_wdata_next   = d_wdata;
        load_next      = ~d_we;
        gnt_cnt_d_next = gnt_cnt_d + 16'd1;
      end else begin
        i_gnt_next     = 1'b1;
        m_addr_next    = i_addr;
        load_next      = 1'b1;
        gnt_cnt_i_next = gnt_cnt_i + 16'd1;
      end
    end
  end

endmodule
